// File: rtl/axis_compress_verb.sv
// -----------------------------------------------------------------------------
// axis_compress_verb
//
// Run-length compressor for AXI-stream address streams. Each incoming beat on
// the unzip side is an ASIZE-bit address. Runs of addresses that each equal the
// previous address plus STEP (modulo 2^ASIZE) collapse into one record on the
// zip side: {start address, run length - 1}. Zip records feed the range
// uncompressor directly and expand back to the original beats and tlast.
//
// Ports
//   aclk               clock
//   aresetn            asynchronous active-low reset (async assert, sync release)
//   axis_unzip_tdata   incoming address                        [ASIZE-1:0]
//   axis_unzip_tvalid  incoming beat valid
//   axis_unzip_tlast   last beat of packet
//   axis_unzip_tready  beat accepted when tvalid && tready
//   axis_zip_tdata     record {start, length-1}                [ASIZE+LSIZE-1:0]
//   axis_zip_tvalid    record valid
//   axis_zip_tlast     last record of packet
//   axis_zip_tready    downstream ready
// -----------------------------------------------------------------------------
module axis_compress_verb #(
   parameter int ASIZE = 8,
   parameter int LSIZE = 8,
   parameter int STEP  = 1
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [ASIZE-1:0]       axis_unzip_tdata,
   input  logic                   axis_unzip_tvalid,
   input  logic                   axis_unzip_tlast,
   output logic                   axis_unzip_tready,
   output logic [ASIZE+LSIZE-1:0] axis_zip_tdata,
   output logic                   axis_zip_tvalid,
   output logic                   axis_zip_tlast,
   input  logic                   axis_zip_tready
);

   typedef enum logic [1:0] {
      S_IDLE,   // no open run
      S_RUN,    // run open in run_start/run_cnt/last_addr
      S_FLUSH   // single-beat closing record waiting in hold_addr
   } state_t;

   localparam logic [LSIZE-1:0] CNT_MAX = '1;

   state_t           state;
   logic [ASIZE-1:0] run_start;
   logic [LSIZE-1:0] run_cnt;     // beats in open run minus one
   logic [ASIZE-1:0] last_addr;
   logic [ASIZE-1:0] hold_addr;   // beat that opened the pending FLUSH record

   logic [ASIZE-1:0] expected_addr;
   logic             slot_free;
   logic             accept;
   logic             continuation;

   // Truncation to ASIZE bits makes the wrap from all-ones to zero consecutive.
   assign expected_addr = last_addr + ASIZE'(STEP);
   assign continuation  = (axis_unzip_tdata == expected_addr) && (run_cnt != CNT_MAX);
   assign slot_free     = !axis_zip_tvalid || axis_zip_tready;

   // NOTE: state resets to IDLE, which alone would raise tready during reset;
   // gating with aresetn keeps the input closed for the whole reset window.
   assign axis_unzip_tready = aresetn && (state != S_FLUSH) && slot_free;
   assign accept            = axis_unzip_tvalid && axis_unzip_tready;

   // NOTE: all state and outputs update with non-blocking assignments so every
   // read in this block sees the pre-edge value, and later loads override the
   // earlier slot-clear without ordering hazards.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state           <= S_IDLE;
         run_start       <= '0;
         run_cnt         <= '0;
         last_addr       <= '0;
         hold_addr       <= '0;
         axis_zip_tdata  <= '0;
         axis_zip_tvalid <= 1'b0;
         axis_zip_tlast  <= 1'b0;
      end else begin
         // Slot empties on handshake unless a load below refills it.
         if (axis_zip_tvalid && axis_zip_tready)
            axis_zip_tvalid <= 1'b0;

         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  if (axis_unzip_tlast) begin
                     // Single-beat packet: emit directly, no run opened.
                     axis_zip_tvalid <= 1'b1;
                     axis_zip_tdata  <= {axis_unzip_tdata, {LSIZE{1'b0}}};
                     axis_zip_tlast  <= 1'b1;
                  end else begin
                     run_start <= axis_unzip_tdata;
                     run_cnt   <= '0;
                     last_addr <= axis_unzip_tdata;
                     state     <= S_RUN;
                  end
               end
            end

            S_RUN: begin
               if (accept) begin
                  if (continuation) begin
                     if (axis_unzip_tlast) begin
                        axis_zip_tvalid <= 1'b1;
                        axis_zip_tdata  <= {run_start, run_cnt + LSIZE'(1)};
                        axis_zip_tlast  <= 1'b1;
                        state           <= S_IDLE;
                     end else begin
                        run_cnt   <= run_cnt + LSIZE'(1);
                        last_addr <= axis_unzip_tdata;
                     end
                  end else begin
                     // Break: close the open run, the new beat starts another.
                     axis_zip_tvalid <= 1'b1;
                     axis_zip_tdata  <= {run_start, run_cnt};
                     axis_zip_tlast  <= 1'b0;
                     if (axis_unzip_tlast) begin
                        hold_addr <= axis_unzip_tdata;
                        state     <= S_FLUSH;
                     end else begin
                        run_start <= axis_unzip_tdata;
                        run_cnt   <= '0;
                        last_addr <= axis_unzip_tdata;
                     end
                  end
               end
            end

            S_FLUSH: begin
               if (slot_free) begin
                  axis_zip_tvalid <= 1'b1;
                  axis_zip_tdata  <= {hold_addr, {LSIZE{1'b0}}};
                  axis_zip_tlast  <= 1'b1;
                  state           <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_compress_verb.sv
// -----------------------------------------------------------------------------
// tb_axis_compress_verb
//
// Scoreboard bench for axis_compress_verb (ASIZE=8, LSIZE=2, STEP=1). Stimulus
// pushes expected records into exp_q; a monitor pops and compares every zip
// handshake, and expands each record back into addresses that must match the
// beats that were accepted (loopback through an uncompressor model).
// -----------------------------------------------------------------------------
module tb_axis_compress_verb;

   localparam int ASIZE       = 8;
   localparam int LSIZE       = 2;
   localparam int BEAT_BUDGET = 60;

   typedef logic [ASIZE-1:0] addr_q_t[$];

   typedef struct {
      logic [ASIZE-1:0] start;
      logic [LSIZE-1:0] len;
      logic             last;
   } rec_t;

   typedef struct {
      logic [ASIZE-1:0] addr;
      logic             last;
   } beat_t;

   logic                   aclk;
   logic                   aresetn;
   logic [ASIZE-1:0]       axis_unzip_tdata;
   logic                   axis_unzip_tvalid;
   logic                   axis_unzip_tlast;
   logic                   axis_unzip_tready;
   logic [ASIZE+LSIZE-1:0] axis_zip_tdata;
   logic                   axis_zip_tvalid;
   logic                   axis_zip_tlast;
   logic                   axis_zip_tready;

   int    tests;
   int    fails;
   rec_t  exp_q[$];
   beat_t beat_q[$];
   bit    rand_mode;
   logic  tready_force;

   axis_compress_verb #(
      .ASIZE (ASIZE),
      .LSIZE (LSIZE),
      .STEP  (1)
   ) dut (
      .aclk              (aclk),
      .aresetn           (aresetn),
      .axis_unzip_tdata  (axis_unzip_tdata),
      .axis_unzip_tvalid (axis_unzip_tvalid),
      .axis_unzip_tlast  (axis_unzip_tlast),
      .axis_unzip_tready (axis_unzip_tready),
      .axis_zip_tdata    (axis_zip_tdata),
      .axis_zip_tvalid   (axis_zip_tvalid),
      .axis_zip_tlast    (axis_zip_tlast),
      .axis_zip_tready   (axis_zip_tready)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Downstream ready driver: fixed level or random per cycle.
   initial begin
      axis_zip_tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         axis_zip_tready = rand_mode ? 1'($urandom_range(0, 1)) : tready_force;
      end
   end

   // Monitor: compare each presented record against the scoreboard front.
   initial begin
      rec_t             r;
      beat_t            b;
      logic [ASIZE-1:0] act_start;
      logic [LSIZE-1:0] act_len;
      forever begin
         @(negedge aclk);
         if (aresetn && axis_zip_tvalid) begin
            act_start = axis_zip_tdata[ASIZE+LSIZE-1:LSIZE];
            act_len   = axis_zip_tdata[LSIZE-1:0];
            if (exp_q.size() == 0) begin
               check("rec_pending", 32'(exp_q.size()), 32'd1);
            end else begin
               r = exp_q[0];
               check("rec_start", 32'(act_start), 32'(r.start));
               check("rec_len", 32'(act_len), 32'(r.len));
               check("rec_last", 32'(axis_zip_tlast), 32'(r.last));
               if (axis_zip_tready) begin
                  void'(exp_q.pop_front());
                  for (int k = 0; k <= int'(act_len); k++) begin
                     if (beat_q.size() == 0) begin
                        check("loop_beat_pending", 32'(beat_q.size()), 32'd1);
                     end else begin
                        b = beat_q.pop_front();
                        check("loop_addr", 32'(ASIZE'(act_start + ASIZE'(k))), 32'(b.addr));
                        check("loop_last", 32'((k == int'(act_len)) && axis_zip_tlast), 32'(b.last));
                     end
                  end
               end else begin
                  check("stall_unzip_tready", 32'(axis_unzip_tready), 32'd0);
               end
            end
         end
      end
   end

   task automatic push_rec(input logic [ASIZE-1:0] s, input logic [LSIZE-1:0] l, input logic last);
      rec_t r;
      r.start = s;
      r.len   = l;
      r.last  = last;
      exp_q.push_back(r);
   endtask

   // Reference compressor used for random packets.
   task automatic model(input addr_q_t pkt);
      logic [ASIZE-1:0] start;
      logic [LSIZE-1:0] cnt;
      start = pkt[0];
      cnt   = '0;
      for (int i = 1; i < pkt.size(); i++) begin
         if (pkt[i] == ASIZE'(pkt[i-1] + 8'd1) && cnt != 2'd3) begin
            cnt = cnt + 2'd1;
         end else begin
            push_rec(start, cnt, 1'b0);
            start = pkt[i];
            cnt   = '0;
         end
      end
      push_rec(start, cnt, 1'b1);
   endtask

   task automatic send(input logic [ASIZE-1:0] d, input logic last, input bit track);
      int    n;
      beat_t b;
      n = 0;
      axis_unzip_tdata  = d;
      axis_unzip_tlast  = last;
      axis_unzip_tvalid = 1'b1;
      @(negedge aclk);
      while (!axis_unzip_tready && n < BEAT_BUDGET) begin
         n++;
         @(negedge aclk);
      end
      if (!axis_unzip_tready) begin
         tests++;
         fails++;
         $display("FAIL beat_accept_timeout: beat %0d not accepted within %0d cycles", d, BEAT_BUDGET);
      end else begin
         @(posedge aclk);
         #1;
         if (track) begin
            b.addr = d;
            b.last = last;
            beat_q.push_back(b);
         end
      end
      axis_unzip_tvalid = 1'b0;
      axis_unzip_tlast  = 1'b0;
   endtask

   task automatic send_pkt(input addr_q_t pkt, input bit track);
      for (int i = 0; i < pkt.size(); i++)
         send(pkt[i], (i == pkt.size() - 1), track);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_zip_tvalid"}, 32'(axis_zip_tvalid), 32'd0);
      check({tag, "_zip_tdata"}, 32'(axis_zip_tdata), 32'd0);
      check({tag, "_zip_tlast"}, 32'(axis_zip_tlast), 32'd0);
      check({tag, "_unzip_tready"}, 32'(axis_unzip_tready), 32'd0);
   endtask

   initial begin
      addr_q_t pkt;
      logic [ASIZE-1:0] a;
      tests             = 0;
      fails             = 0;
      rand_mode         = 1'b0;
      tready_force      = 1'b1;
      aresetn           = 1'b0;
      axis_unzip_tdata  = '0;
      axis_unzip_tvalid = 1'b0;
      axis_unzip_tlast  = 1'b0;

      #12;
      check_reset_outputs("por");
      @(negedge aclk);
      aresetn = 1'b1;
      idle(2);

      // Simple run, record one cycle after the closing beat.
      push_rec(8'd5, 2'd3, 1'b1);
      send_pkt('{8'd5, 8'd6, 8'd7, 8'd8}, 1'b1);
      check("t1_latency_valid", 32'(axis_zip_tvalid), 32'd1);
      check("t1_latency_data", 32'(axis_zip_tdata), 32'({8'd5, 2'd3}));
      idle(4);

      // Two runs in one packet.
      push_rec(8'd3, 2'd1, 1'b0);
      push_rec(8'd10, 2'd2, 1'b1);
      send_pkt('{8'd3, 8'd4, 8'd10, 8'd11, 8'd12}, 1'b1);
      idle(4);

      // Break on tlast forces a FLUSH cycle.
      push_rec(8'd7, 2'd0, 1'b0);
      push_rec(8'd20, 2'd0, 1'b1);
      send_pkt('{8'd7, 8'd20}, 1'b1);
      check("t3_flush_tready", 32'(axis_unzip_tready), 32'd0);
      idle(4);

      // Address wrap counts as consecutive.
      push_rec(8'd254, 2'd2, 1'b1);
      send_pkt('{8'd254, 8'd255, 8'd0}, 1'b1);
      idle(4);

      // Saturation: four-beat run closes when the fifth beat arrives.
      push_rec(8'd0, 2'd3, 1'b0);
      push_rec(8'd4, 2'd1, 1'b1);
      send_pkt('{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, 1'b1);
      idle(4);

      // Backpressure: downstream stalls 10 cycles mid-packet.
      push_rec(8'd3, 2'd1, 1'b0);
      push_rec(8'd10, 2'd2, 1'b1);
      fork
         send_pkt('{8'd3, 8'd4, 8'd10, 8'd11, 8'd12}, 1'b1);
         begin
            repeat (2) @(posedge aclk);
            tready_force = 1'b0;
            repeat (10) @(posedge aclk);
            tready_force = 1'b1;
         end
      join
      idle(6);

      // Reset mid-run discards the open run.
      send(8'd1, 1'b0, 1'b0);
      send(8'd2, 1'b0, 1'b0);
      aresetn = 1'b0;
      #1;
      check_reset_outputs("rst_run");
      @(negedge aclk);
      aresetn = 1'b1;
      idle(2);

      // Reset while in FLUSH discards both the slot and the held record.
      send(8'd7, 1'b0, 1'b0);
      send(8'd20, 1'b1, 1'b0);
      check("pre_flush_tready", 32'(axis_unzip_tready), 32'd0);
      check("pre_flush_zip_tvalid", 32'(axis_zip_tvalid), 32'd1);
      aresetn = 1'b0;
      #1;
      check_reset_outputs("rst_flush");
      @(negedge aclk);
      aresetn = 1'b1;
      idle(2);

      push_rec(8'd9, 2'd0, 1'b1);
      send_pkt('{8'd9}, 1'b1);
      check("t9_latency_valid", 32'(axis_zip_tvalid), 32'd1);
      check("t9_latency_data", 32'(axis_zip_tdata), 32'({8'd9, 2'd0}));
      idle(4);

      // Random traffic with random downstream ready.
      rand_mode = 1'b1;
      for (int p = 0; p < 30; p++) begin
         pkt.delete();
         a = 8'($urandom_range(0, 255));
         for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
            pkt.push_back(a);
            a = ($urandom_range(0, 9) < 7) ? ASIZE'(a + 8'd1) : 8'($urandom_range(0, 255));
         end
         model(pkt);
         send_pkt(pkt, 1'b1);
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end
      rand_mode    = 1'b0;
      tready_force = 1'b1;

      for (int i = 0; i < 500 && exp_q.size() != 0; i++)
         @(posedge aclk);
      idle(2);
      check("drain_exp_q", 32'(exp_q.size()), 32'd0);
      check("drain_beat_q", 32'(beat_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
